// File: rtl/tt_um_brs_3.sv
// Registered 8-bit barrel rotate/shift/permute unit for the TinyTapeout tile.
// Each valid cycle transforms ui_in (or the previous result when FB=1) into R.
module tt_um_brs_3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_REV  = 3'b101;
    localparam logic [2:0] OP_NSW  = 3'b110;

    logic [2:0] amt;
    logic [2:0] op;
    logic       valid;
    logic       fb;

    logic [7:0] r;
    logic [7:0] src;
    logic       left;
    logic       rot;
    logic       arith;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] s3;
    logic       fill1;
    logic [1:0] fill2;
    logic [3:0] fill4;
    logic [7:0] shifted;
    logic [7:0] result;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) begin
            y[i] = x[7-i];
        end
        return y;
    endfunction

    assign amt   = uio_in[2:0];
    assign op    = uio_in[5:3];
    assign valid = uio_in[6];
    assign fb    = uio_in[7];

    assign src = fb ? r : ui_in;

    // Left ops reuse the right shifter by reversing the operand before and after.
    assign left  = (op == OP_SLL) || (op == OP_ROL);
    assign rot   = (op == OP_ROL) || (op == OP_ROR);
    assign arith = (op == OP_SRA);

    assign s0 = left ? rev8(src) : src;

    // Three log stages (1, 2, 4); fill is wrapped bits, sign copies, or zeros.
    always_comb begin
        fill1 = rot ? s0[0]   : (arith ? s0[7]        : 1'b0);
        s1    = amt[0] ? {fill1, s0[7:1]} : s0;
        fill2 = rot ? s1[1:0] : (arith ? {2{s1[7]}}   : 2'b00);
        s2    = amt[1] ? {fill2, s1[7:2]} : s1;
        fill4 = rot ? s2[3:0] : (arith ? {4{s2[7]}}   : 4'b0000);
        s3    = amt[2] ? {fill4, s2[7:4]} : s2;
    end

    assign shifted = left ? rev8(s3) : s3;

    always_comb begin
        result = src;
        case (op)
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: result = shifted;
            OP_REV:  result = rev8(src);
            OP_NSW:  result = {src[3:0], src[7:4]};
            default: result = src;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r <= 8'h00;
        end else if (ena && valid) begin
            r <= result;
        end
    end

    assign uo_out  = r;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_brs_3.sv
// Directed bench for tt_um_brs_3: hand-computed vectors checked with immediate assertions.
module tb_tt_um_brs_3;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int compared;
    int mismatched;

    localparam logic [2:0] SLL  = 3'b000;
    localparam logic [2:0] SRL  = 3'b001;
    localparam logic [2:0] SRA  = 3'b010;
    localparam logic [2:0] ROL  = 3'b011;
    localparam logic [2:0] ROR  = 3'b100;
    localparam logic [2:0] REV  = 3'b101;
    localparam logic [2:0] NSW  = 3'b110;
    localparam logic [2:0] PASS = 3'b111;

    tt_um_brs_3 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, then check the registered result after the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [7:0] a,
                        input logic [2:0] op, input logic [2:0] amt, input logic v,
                        input logic fb, input logic [7:0] exp);
        @(negedge clk);
        rst_n  = r;
        ena    = e;
        ui_in  = a;
        uio_in = {fb, v, op, amt};
        @(posedge clk);
        #1;
        check(tag, uo_out, exp);
        check({tag, "_uio_out"}, uio_out, 8'h00);
        check({tag, "_uio_oe"}, uio_oe, 8'h00);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset with arbitrary inputs
        step("rst0", 1, 1, 8'($urandom_range(0, 255)), PASS, 3'd5, 1, 0, 8'h00);
        step("rst1", 1, 1, 8'($urandom_range(0, 255)), SLL, 3'd1, 1, 1, 8'h00);

        // Shifts and rotates of B1 by 3
        step("sll3", 0, 1, 8'hB1, SLL, 3'd3, 1, 0, 8'h88);
        step("srl3", 0, 1, 8'hB1, SRL, 3'd3, 1, 0, 8'h16);
        step("sra3", 0, 1, 8'hB1, SRA, 3'd3, 1, 0, 8'hF6);
        step("rol3", 0, 1, 8'hB1, ROL, 3'd3, 1, 0, 8'h8D);
        step("ror3", 0, 1, 8'hB1, ROR, 3'd3, 1, 0, 8'h36);

        // Permutes (AMT ignored) and zero amounts
        step("rev",  0, 1, 8'hB1, REV,  3'd6, 1, 0, 8'h8D);
        step("nsw",  0, 1, 8'hB1, NSW,  3'd2, 1, 0, 8'h1B);
        step("pass", 0, 1, 8'hB1, PASS, 3'd7, 1, 0, 8'hB1);
        step("sll0", 0, 1, 8'hB1, SLL,  3'd0, 1, 0, 8'hB1);
        step("ror0", 0, 1, 8'hB1, ROR,  3'd0, 1, 0, 8'hB1);

        // Amount-7 boundaries and other patterns
        step("sll7",   0, 1, 8'hB1, SLL, 3'd7, 1, 0, 8'h80);
        step("sra7p",  0, 1, 8'h7F, SRA, 3'd7, 1, 0, 8'h00);
        step("srl7",   0, 1, 8'hFF, SRL, 3'd7, 1, 0, 8'h01);
        step("rol5",   0, 1, 8'hC3, ROL, 3'd5, 1, 0, 8'h78);
        step("ror6",   0, 1, 8'h81, ROR, 3'd6, 1, 0, 8'h06);
        step("sra2",   0, 1, 8'h40, SRA, 3'd2, 1, 0, 8'h10);

        // Feedback chain
        step("fb_load", 0, 1, 8'hB1, ROL, 3'd3, 1, 0, 8'h8D);
        step("fb_ror",  0, 1, 8'h00, ROR, 3'd3, 1, 1, 8'hB1);
        step("fb_nsw",  0, 1, 8'h00, NSW, 3'd0, 1, 1, 8'h1B);

        // Hold: VALID low, then ena low
        for (int i = 0; i < 3; i++) step("hold_v", 0, 1, 8'hFF, PASS, 3'd0, 0, 0, 8'h1B);
        for (int i = 0; i < 3; i++) step("hold_e", 0, 0, 8'hFF, PASS, 3'd0, 1, 0, 8'h1B);

        // Resume from frozen value
        step("resume", 0, 1, 8'hFF, ROL, 3'd1, 1, 1, 8'h36);

        // Reset priority and post-reset feedback
        step("rst_pri", 1, 1, 8'h5A, PASS, 3'd0, 1, 0, 8'h00);
        step("fb_post", 0, 1, 8'h5A, PASS, 3'd0, 1, 1, 8'h00);
        step("sra7n",   0, 1, 8'h80, SRA,  3'd7, 1, 0, 8'hFF);

        // No combinational path: input change between edges must not reach uo_out
        @(negedge clk);
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = {1'b0, 1'b1, PASS, 3'd0};
        #2;
        check("no_comb", uo_out, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
